// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared state encoding and constants for the digit display slice
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    CLEAR = 2'b10
  } state_e;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] ANODE_IDLE = 4'b1111;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/digit_scan_counter.sv
// rtl/digit_scan_counter.sv - prescaled digit scan index and active-low anode select
module digit_scan_counter
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clock,
  input  logic       reset,
  output logic [1:0] scan_idx_o,
  output logic [3:0] anode_n_o
);

  localparam int            PW   = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] prescale_q, prescale_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    anode_n_q;

  always_comb begin
    prescale_d = prescale_q + PW'(1);
    idx_d      = idx_q;
    if (prescale_q == LAST) begin
      prescale_d = '0;
      idx_d      = idx_q + 2'd1;
    end
  end

  // Anode is registered from the next index so it moves on the same edge as the index.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prescale_q <= '0;
      idx_q      <= 2'd0;
      anode_n_q  <= ANODE_IDLE ^ onehot4(2'd0);
    end else begin
      prescale_q <= prescale_d;
      idx_q      <= idx_d;
      anode_n_q  <= ANODE_IDLE ^ onehot4(idx_d);
    end
  end

  assign scan_idx_o = idx_q;
  assign anode_n_o  = anode_n_q;

endmodule

// File: rtl/digit_entry_controller.sv
// rtl/digit_entry_controller.sv - keyed digit load / clear sequencer with display scan mux
module digit_entry_controller
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_value,
  input  logic       clear_req,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  output logic [3:0] reg_enable,
  output logic [3:0] reg_next,
  output logic [2:0] count,
  output logic       full,
  output logic       busy,
  output logic [3:0] anode_n,
  output logic [3:0] scan_digit
);

  localparam logic [2:0] FULL_COUNT = 3'(NUM_DIGITS);

  state_e     state_q, state_d;
  logic [1:0] clr_idx_q, clr_idx_d;
  logic [2:0] count_q, count_d;
  logic       full_q, full_d;
  logic       busy_q, busy_d;
  logic [3:0] en_q, en_d;
  logic [3:0] next_q, next_d;
  logic [1:0] scan_idx;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    count_d   = count_q;
    full_d    = full_q;
    busy_d    = busy_q;
    en_d      = 4'b0000;
    next_d    = next_q;
    case (state_q)
      IDLE: begin
        // clear_req takes priority; a coincident key is simply dropped.
        if (clear_req) begin
          state_d   = CLEAR;
          clr_idx_d = 2'd0;
          en_d      = onehot4(2'd0);
          next_d    = 4'h0;
          busy_d    = 1'b1;
        end else if (key_valid && (count_q < FULL_COUNT)) begin
          state_d = LOAD;
          en_d    = onehot4(count_q[1:0]);
          next_d  = key_value;
          busy_d  = 1'b1;
        end
      end
      LOAD: begin
        state_d = IDLE;
        count_d = count_q + 3'd1;
        full_d  = ((count_q + 3'd1) == FULL_COUNT);
        busy_d  = 1'b0;
      end
      CLEAR: begin
        if (clr_idx_q == 2'd3) begin
          state_d = IDLE;
          count_d = 3'd0;
          full_d  = 1'b0;
          busy_d  = 1'b0;
        end else begin
          clr_idx_d = clr_idx_q + 2'd1;
          en_d      = onehot4(clr_idx_q + 2'd1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      clr_idx_q <= 2'd0;
      count_q   <= 3'd0;
      full_q    <= 1'b0;
      busy_q    <= 1'b0;
      en_q      <= 4'b0000;
      next_q    <= 4'h0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      count_q   <= count_d;
      full_q    <= full_d;
      busy_q    <= busy_d;
      en_q      <= en_d;
      next_q    <= next_d;
    end
  end

  digit_scan_counter #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clock      (clock),
    .reset      (reset),
    .scan_idx_o (scan_idx),
    .anode_n_o  (anode_n)
  );

  always_comb begin
    scan_digit = digit0;
    case (scan_idx)
      2'd0:    scan_digit = digit0;
      2'd1:    scan_digit = digit1;
      2'd2:    scan_digit = digit2;
      default: scan_digit = digit3;
    endcase
  end

  assign reg_enable = en_q;
  assign reg_next   = next_q;
  assign count      = count_q;
  assign full       = full_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_digit_entry_controller.sv
// tb/tb_digit_entry_controller.sv - scoreboard bench for digit_entry_controller with modelled digit registers
module tb_digit_entry_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_value = 4'h0;
  logic       clear_req = 1'b0;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] reg_enable, reg_next, anode_n, scan_digit;
  logic [2:0] count;
  logic       full, busy;

  typedef struct packed {
    logic [3:0] en;
    logic [3:0] nx;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t seen_q[$];
  int    tests = 0;
  int    fails = 0;
  int    multi_hot = 0;

  localparam logic [3:0] KEYS [5] = '{4'h3, 4'hA, 4'h7, 4'hF, 4'h1};

  digit_entry_controller #(.SCAN_DIV(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_value  (key_value),
    .clear_req  (clear_req),
    .digit0     (d0),
    .digit1     (d1),
    .digit2     (d2),
    .digit3     (d3),
    .reg_enable (reg_enable),
    .reg_next   (reg_next),
    .count      (count),
    .full       (full),
    .busy       (busy),
    .anode_n    (anode_n),
    .scan_digit (scan_digit)
  );

  always #5 clock = ~clock;

  // Digit register bank as it sits in the parent display top.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      d0 <= 4'h0; d1 <= 4'h0; d2 <= 4'h0; d3 <= 4'h0;
    end else begin
      if (reg_enable[0]) d0 <= reg_next;
      if (reg_enable[1]) d1 <= reg_next;
      if (reg_enable[2]) d2 <= reg_next;
      if (reg_enable[3]) d3 <= reg_next;
    end
  end

  task automatic tick();
    @(negedge clock);
    if (reg_enable != 4'b0000) seen_q.push_back(xfer_t'({reg_enable, reg_next}));
    if ((reg_enable & (reg_enable - 4'd1)) != 4'b0000) multi_hot++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push_clear();
    for (int i = 0; i < 4; i++) exp_q.push_back(xfer_t'({4'(1 << i), 4'h0}));
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    tests++;
    if ({reg_enable, reg_next, count, full, busy} !== 15'd0) begin
      fails++;
      $display("FAIL reset_outputs en=%b nx=%h cnt=%0d full=%b busy=%b want all zero", reg_enable, reg_next, count, full, busy);
    end
    tests++;
    if (anode_n !== 4'b1110 || scan_digit !== 4'h0) begin
      fails++;
      $display("FAIL reset_scan anode=%b digit=%h want 1110/0", anode_n, scan_digit);
    end
    reset = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      logic [3:0] want;
      if (k > 0) @(negedge clock);
      want = ~(4'b0001 << ((k / 4) % 4));
      tests++;
      if (anode_n !== want) begin
        fails++;
        $display("FAIL anode_step k=%0d got %b want %b", k, anode_n, want);
      end
    end
  endtask

  task automatic test_keys();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(xfer_t'({4'(1 << i), KEYS[i]}));
      key_valid = 1'b1;
      key_value = KEYS[i];
      tick();
      key_valid = 1'b0;
      idle(2);
    end
    tests++;
    if (seen_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL keys_xfer_count got %0d want %0d", seen_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && seen_q.size() > 0) begin
      xfer_t e, s;
      e = exp_q.pop_front();
      s = seen_q.pop_front();
      tests++;
      if (s !== e) begin
        fails++;
        $display("FAIL keys_xfer got en=%b nx=%h want en=%b nx=%h", s.en, s.nx, e.en, e.nx);
      end
    end
    exp_q.delete(); seen_q.delete();
    tests++;
    if (count !== 3'd4 || full !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL keys_full cnt=%0d full=%b busy=%b want 4/1/0", count, full, busy);
    end
    tests++;
    if ({d3, d2, d1, d0} !== 16'hF7A3) begin
      fails++;
      $display("FAIL keys_digits got %h want F7A3", {d3, d2, d1, d0});
    end
  endtask

  task automatic test_clear();
    int busy_cycles;
    push_clear();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    busy_cycles = busy ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy) busy_cycles++;
    end
    tests++;
    if (busy_cycles != 4) begin
      fails++;
      $display("FAIL clear_busy got %0d cycles want 4", busy_cycles);
    end
    tests++;
    if (seen_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL clear_xfer_count got %0d want %0d", seen_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && seen_q.size() > 0) begin
      xfer_t e, s;
      e = exp_q.pop_front();
      s = seen_q.pop_front();
      tests++;
      if (s !== e) begin
        fails++;
        $display("FAIL clear_xfer got en=%b nx=%h want en=%b nx=%h", s.en, s.nx, e.en, e.nx);
      end
    end
    exp_q.delete(); seen_q.delete();
    tests++;
    if ({d3, d2, d1, d0} !== 16'h0000 || count !== 3'd0 || full !== 1'b0) begin
      fails++;
      $display("FAIL clear_final digits=%h cnt=%0d full=%b want 0000/0/0", {d3, d2, d1, d0}, count, full);
    end
  endtask

  task automatic test_clear_wins();
    exp_q.push_back(xfer_t'({4'b0001, 4'h5}));
    key_valid = 1'b1; key_value = 4'h5;
    tick();
    key_valid = 1'b0;
    idle(2);
    tests++;
    if (count !== 3'd1) begin
      fails++;
      $display("FAIL clear_wins_pre cnt=%0d want 1", count);
    end
    push_clear();
    key_valid = 1'b1; key_value = 4'hE; clear_req = 1'b1;
    tick();
    key_valid = 1'b0; clear_req = 1'b0;
    idle(5);
    tests++;
    if (seen_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL clear_wins_xfer_count got %0d want %0d", seen_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && seen_q.size() > 0) begin
      xfer_t e, s;
      e = exp_q.pop_front();
      s = seen_q.pop_front();
      tests++;
      if (s !== e) begin
        fails++;
        $display("FAIL clear_wins_xfer got en=%b nx=%h want en=%b nx=%h", s.en, s.nx, e.en, e.nx);
      end
    end
    exp_q.delete(); seen_q.delete();
    tests++;
    if ({d3, d2, d1, d0} !== 16'h0000 || count !== 3'd0) begin
      fails++;
      $display("FAIL clear_wins_final digits=%h cnt=%0d want 0000/0", {d3, d2, d1, d0}, count);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(xfer_t'({4'b0001, 4'h9}));
    exp_q.push_back(xfer_t'({4'b0010, 4'hC}));
    key_valid = 1'b1; key_value = 4'h9;
    tick();
    key_value = 4'hB;
    tick();
    tests++;
    if (count !== 3'd1) begin
      fails++;
      $display("FAIL b2b_mid cnt=%0d want 1", count);
    end
    key_value = 4'hC;
    tick();
    key_valid = 1'b0;
    idle(2);
    tests++;
    if (seen_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL b2b_xfer_count got %0d want %0d", seen_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && seen_q.size() > 0) begin
      xfer_t e, s;
      e = exp_q.pop_front();
      s = seen_q.pop_front();
      tests++;
      if (s !== e) begin
        fails++;
        $display("FAIL b2b_xfer got en=%b nx=%h want en=%b nx=%h", s.en, s.nx, e.en, e.nx);
      end
    end
    exp_q.delete(); seen_q.delete();
    tests++;
    if (count !== 3'd2 || {d3, d2, d1, d0} !== 16'h00C9) begin
      fails++;
      $display("FAIL b2b_final cnt=%0d digits=%h want 2/00C9", count, {d3, d2, d1, d0});
    end
  endtask

  task automatic test_scan_digit();
    logic [3:0] want;
    int         pos;
    int         zeros;
    for (int k = 0; k < 16; k++) begin
      tick();
      pos = 0; zeros = 0;
      for (int j = 0; j < 4; j++) if (anode_n[j] == 1'b0) begin pos = j; zeros++; end
      case (pos)
        0: want = d0;
        1: want = d1;
        2: want = d2;
        default: want = d3;
      endcase
      tests++;
      if (zeros != 1 || scan_digit !== want) begin
        fails++;
        $display("FAIL scan_digit anode=%b got %h want %h", anode_n, scan_digit, want);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tick();
    tests++;
    if (reg_enable !== 4'b0010 || count !== 3'd2) begin
      fails++;
      $display("FAIL midclear_pre en=%b cnt=%0d want 0010/2", reg_enable, count);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (reg_enable !== 4'b0000 || busy !== 1'b0 || count !== 3'd0 || full !== 1'b0) begin
      fails++;
      $display("FAIL midclear_reset en=%b busy=%b cnt=%0d full=%b want 0000/0/0/0", reg_enable, busy, count, full);
    end
    tests++;
    if ({d3, d2, d1, d0} !== 16'h0000 || anode_n !== 4'b1110) begin
      fails++;
      $display("FAIL midclear_regs digits=%h anode=%b want 0000/1110", {d3, d2, d1, d0}, anode_n);
    end
    @(negedge clock);
    reset = 1'b1;
    exp_q.delete(); seen_q.delete();
    idle(3);
    tests++;
    if (seen_q.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midclear_resume xfers=%0d busy=%b want 0/0", seen_q.size(), busy);
    end
    exp_q.push_back(xfer_t'({4'b0001, 4'h6}));
    key_valid = 1'b1; key_value = 4'h6;
    tick();
    key_valid = 1'b0;
    idle(2);
    tests++;
    if (seen_q.size() != 1 || seen_q[0] !== exp_q[0] || count !== 3'd1) begin
      fails++;
      $display("FAIL midclear_idle xfers=%0d cnt=%0d want 1 xfer en=0001 nx=6 cnt=1", seen_q.size(), count);
    end
    exp_q.delete(); seen_q.delete();
    tests++;
    if (multi_hot != 0) begin
      fails++;
      $display("FAIL enable_onehot got %0d multi-hot cycles want 0", multi_hot);
    end
  endtask

  initial begin
    test_reset();
    test_keys();
    test_clear();
    test_clear_wins();
    test_back_to_back();
    test_scan_digit();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
